// File: rtl/score_collector.sv
// score_collector: gathers (node ID, score) beats from the NoC into a packed
// N-entry score vector. Once every node has reported in the current round, the
// vector is offered to the top-10 sorter with a valid/ack handshake. There is a
// single vector buffer, and no beats are accepted while the vector is offered.
module score_collector #(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                in_id,
  input  logic [WIDTH-1:0]          in_score,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ack,
  output logic [N*(WIDTH+6)-1:0]    scores_out,
  output logic [6:0]                count,
  output logic                      dup_err,
  output logic                      oob_err,
  output logic [7:0]                rounds
);

  localparam int         ENTRY_W = WIDTH + 6;
  localparam int         IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam logic [6:0] N_CNT   = 7'(N);

  typedef enum logic {
    COLLECT = 1'b0,
    PUBLISH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       seen_q, seen_d;
  logic [6:0]         count_q, count_d;
  logic [7:0]         rounds_q, rounds_d;
  logic               dup_q, dup_d;
  logic               oob_q, oob_d;
  logic [ENTRY_W-1:0] entry_q [N];

  logic               accept;
  logic               id_ok;
  logic               id_seen;
  logic               new_id;
  logic               round_done;
  logic               wr_en;
  logic [IDX_W-1:0]   idx;

  // A beat aborted by a same-edge flush is treated as never accepted.
  assign accept     = in_valid && in_ready && !flush;
  assign id_ok      = {1'b0, in_id} < N_CNT;
  assign idx        = in_id[IDX_W-1:0];
  assign id_seen    = id_ok && seen_q[idx];
  assign new_id     = accept && id_ok && !id_seen;
  // flush takes precedence over the sorter's ack on the same edge.
  assign round_done = (state_q == PUBLISH) && out_ack && !flush;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of block ordering.
    if (reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fill the vector, offer it, return on ack or flush.
  always_comb begin
    // NOTE: default assignment first, so no path through the block leaves
    // state_d unassigned and a latch can never be inferred.
    state_d = state_q;
    if (flush) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (new_id && (count_q + 7'd1 == N_CNT)) state_d = PUBLISH;
        PUBLISH: if (out_ack) state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  // Output decode: handshake signals are pure decodes of the state register.
  always_comb begin
    in_ready  = (state_q == COLLECT);
    out_valid = (state_q == PUBLISH);
  end

  // Round bookkeeping: seen mask, distinct count, error pulses, round counter.
  always_comb begin
    seen_d   = seen_q;
    count_d  = count_q;
    rounds_d = rounds_q;
    dup_d    = 1'b0;
    oob_d    = 1'b0;
    wr_en    = 1'b0;
    if (flush) begin
      seen_d  = '0;
      count_d = '0;
    end else if (round_done) begin
      seen_d   = '0;
      count_d  = '0;
      rounds_d = rounds_q + 8'd1;
    end else if (accept) begin
      if (!id_ok) begin
        oob_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (id_seen) begin
          dup_d = 1'b1;
        end else begin
          seen_d[idx] = 1'b1;
          count_d     = count_q + 7'd1;
        end
      end
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_q   <= '0;
      count_q  <= '0;
      rounds_q <= '0;
      dup_q    <= 1'b0;
      oob_q    <= 1'b0;
    end else begin
      seen_q   <= seen_d;
      count_q  <= count_d;
      rounds_q <= rounds_d;
      dup_q    <= dup_d;
      oob_q    <= oob_d;
    end
  end

  // Vector storage: one entry per node, last accepted score for that ID wins.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: this storage is deliberately reset, because the published vector
    // must read all-zero right after reset; storage that only needs valid data
    // after a write would normally be left unreset.
    if (reset) begin
      for (int m = 0; m < N; m++) entry_q[m] <= '0;
    end else if (wr_en) begin
      entry_q[idx] <= {in_score, in_id};
    end
  end

  // Pack entries into the flat vector; entry m sits at bits m*ENTRY_W upward.
  always_comb begin
    scores_out = '0;
    for (int m = 0; m < N; m++) scores_out[m*ENTRY_W +: ENTRY_W] = entry_q[m];
  end

  assign count   = count_q;
  assign dup_err = dup_q;
  assign oob_err = oob_q;
  assign rounds  = rounds_q;

endmodule

// File: tb/tb_score_collector.sv
// Testbench for score_collector: a table of single-beat vectors on an N=32
// instance, hand-written multi-cycle sequences and randomized rounds on an N=64
// instance. The N=64 instance is checked every cycle against a set-based model.
module tb_score_collector;

  localparam int N   = 64;
  localparam int N32 = 32;
  localparam int W   = 16;
  localparam int E   = W + 6;

  logic           clk = 1'b0;
  logic           reset;
  logic           v64, v32, flush, out_ack;
  logic [5:0]     in_id;
  logic [W-1:0]   in_score;

  logic           rdy64, ov64, dup64, oob64;
  logic [6:0]     cnt64;
  logic [7:0]     rnd64;
  logic [N*E-1:0] so64;

  logic             rdy32, ov32, dup32, oob32;
  logic [6:0]       cnt32;
  logic [7:0]       rnd32;
  logic [N32*E-1:0] so32;

  score_collector #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(v64), .in_ready(rdy64), .in_id(in_id),
    .in_score(in_score), .flush(flush), .out_valid(ov64), .out_ack(out_ack),
    .scores_out(so64), .count(cnt64), .dup_err(dup64), .oob_err(oob64),
    .rounds(rnd64)
  );

  score_collector #(.N(N32), .WIDTH(W)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32), .in_id(in_id),
    .in_score(in_score), .flush(flush), .out_valid(ov32), .out_ack(out_ack),
    .scores_out(so32), .count(cnt32), .dup_err(dup32), .oob_err(oob32),
    .rounds(rnd32)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the set of IDs reported this round, the last value written
  // per slot, whether the vector is on offer, and the completed-round count.
  bit          m_pub;
  bit          m_seen [N];
  logic [E-1:0] m_slot [N];
  int          m_rounds;
  bit          m_dup, m_oob;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_seen[i]);
    return c;
  endfunction

  task automatic model_reset();
    m_pub = 0; m_rounds = 0; m_dup = 0; m_oob = 0;
    for (int i = 0; i < N; i++) begin
      m_seen[i] = 0;
      m_slot[i] = '0;
    end
  endtask

  task automatic model_clear_round();
    for (int i = 0; i < N; i++) m_seen[i] = 0;
    m_pub = 0;
  endtask

  // One clock edge of the collector's behaviour, from the rules of the block.
  task automatic model_edge(input bit v, input logic [5:0] id, input logic [W-1:0] sc,
                            input bit fl, input bit ack);
    m_dup = 0;
    m_oob = 0;
    if (fl) begin
      model_clear_round();
    end else if (m_pub) begin
      if (ack) begin
        model_clear_round();
        m_rounds = (m_rounds + 1) % 256;
      end
    end else if (v) begin
      if (int'(id) >= N) begin
        m_oob = 1;
      end else begin
        m_dup      = m_seen[id];
        m_seen[id] = 1;
        m_slot[id] = {sc, id};
        if (m_count() == N) m_pub = 1;
      end
    end
  endtask

  // Compare the whole vector, reporting the first differing entry.
  task automatic check_vec(input string tag);
    int bad = -1;
    int m;
    for (int i = 0; i < N; i++)
      if (bad < 0 && so64[i*E +: E] !== m_slot[i]) bad = i;
    m = (bad < 0) ? 0 : bad;
    check({tag, ":vector"}, 64'(so64[m*E +: E]), 64'(m_slot[m]));
  endtask

  task automatic check_all(input string tag);
    check({tag, ":count"},     64'(cnt64), 64'(m_count()));
    check({tag, ":dup_err"},   64'(dup64), 64'(m_dup));
    check({tag, ":oob_err"},   64'(oob64), 64'(m_oob));
    check({tag, ":out_valid"}, 64'(ov64),  64'(m_pub));
    check({tag, ":in_ready"},  64'(rdy64), 64'(!m_pub));
    check({tag, ":rounds"},    64'(rnd64), 64'(m_rounds));
    check_vec(tag);
  endtask

  // Drive one cycle on the N=64 instance, advance the model, compare after the edge.
  task automatic cyc(input string tag, input bit v, input logic [5:0] id,
                     input logic [W-1:0] sc, input bit fl, input bit ack);
    v64 = v; in_id = id; in_score = sc; flush = fl; out_ack = ack;
    model_edge(v, id, sc, fl, ack);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic full_round(input string tag, input int base);
    for (int i = 0; i < N; i++) cyc(tag, 1'b1, 6'(i), 16'(base + i), 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    v64 = 0; v32 = 0; flush = 0; out_ack = 0; in_id = '0; in_score = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Randomized round: random IDs (biased toward missing ones), gaps, stray
  // acks while collecting, rare flushes, random hold time before the ack.
  task automatic rand_round(input string tag);
    int guard = 0;
    bit v, fl, ack;
    logic [5:0] id;
    int low;
    while (!m_pub && guard < 3000) begin
      v   = ($urandom_range(3) != 0);
      fl  = ($urandom_range(99) == 0);
      ack = ($urandom_range(7) == 0);
      low = 0;
      while (low < N - 1 && m_seen[low]) low++;
      id  = $urandom_range(1) ? 6'(low) : 6'($urandom_range(N - 1));
      cyc(tag, v, id, 16'($urandom), fl, ack);
      guard++;
    end
    check({tag, ":published"}, 64'(ov64), 64'd1);
    repeat ($urandom_range(5)) cyc(tag, 1'($urandom), 6'($urandom), 16'($urandom), 1'b0, 1'b0);
    cyc(tag, 1'b0, 6'd0, 16'd0, 1'b0, 1'b1);
  endtask

  typedef struct {
    bit         v;
    logic [5:0] id;
    logic [W-1:0] sc;
    bit         fl;
    logic [6:0] e_cnt;
    bit         e_dup;
    bit         e_oob;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [E-1:0] e;

    tbl[0] = '{1, 6'd3,  16'h0011, 0, 7'd1, 0, 0};
    tbl[1] = '{1, 6'd63, 16'h0BAD, 0, 7'd1, 0, 1};
    tbl[2] = '{1, 6'd32, 16'h0BAD, 0, 7'd1, 0, 1};
    tbl[3] = '{1, 6'd3,  16'h0022, 0, 7'd1, 1, 0};
    tbl[4] = '{0, 6'd4,  16'h0044, 0, 7'd1, 0, 0};
    tbl[5] = '{1, 6'd31, 16'h0031, 0, 7'd2, 0, 0};
    tbl[6] = '{1, 6'd5,  16'h0055, 1, 7'd0, 0, 0};
    tbl[7] = '{1, 6'd5,  16'h0056, 0, 7'd1, 0, 0};
    tbl[8] = '{1, 6'd5,  16'h0057, 0, 7'd1, 1, 0};
    tbl[9] = '{0, 6'd0,  16'h0000, 0, 7'd1, 0, 0};

    apply_reset();
    check_all("reset");
    check("reset:n32_in_ready", 64'(rdy32), 64'd1);
    check("reset:n32_vector",   64'(so32 == '0), 64'd1);

    // N=32 instance: single-beat behaviour, out-of-range IDs, flush with beat.
    for (int i = 0; i < 10; i++) begin
      v32 = tbl[i].v; in_id = tbl[i].id; in_score = tbl[i].sc; flush = tbl[i].fl;
      out_ack = 0;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d:count", i),     64'(cnt32), 64'(tbl[i].e_cnt));
      check($sformatf("tbl%0d:dup_err", i),   64'(dup32), 64'(tbl[i].e_dup));
      check($sformatf("tbl%0d:oob_err", i),   64'(oob32), 64'(tbl[i].e_oob));
      check($sformatf("tbl%0d:out_valid", i), 64'(ov32),  64'd0);
      if (i == 2) begin
        check("tbl:oob_entry31_untouched", 64'(so32[31*E +: E]), 64'd0);
        check("tbl:oob_entry0_untouched",  64'(so32[0 +: E]),    64'd0);
      end
    end
    v32 = 0; flush = 0;
    check("tbl:entry3_last_wins", 64'(so32[3*E +: E]),  64'({16'h0022, 6'd3}));
    check("tbl:entry31",          64'(so32[31*E +: E]), 64'({16'h0031, 6'd31}));
    check("tbl:entry5",           64'(so32[5*E +: E]),  64'({16'h0057, 6'd5}));

    apply_reset();

    // In-order round, score = 100 + ID.
    full_round("inorder", 100);
    e = so64[63*E +: E];
    check("inorder:entry63", 64'(e), 64'({16'd163, 6'd63}));
    check("inorder:count64", 64'(cnt64), 64'd64);
    check("inorder:ready0",  64'(rdy64), 64'd0);

    // Beats during PUBLISH are ignored; then ack.
    repeat (10) cyc("hold", 1'b1, 6'd5, 16'hFFFF, 1'b0, 1'b0);
    cyc("ack", 1'b0, 6'd0, 16'd0, 1'b0, 1'b1);
    check("ack:rounds1", 64'(rnd64), 64'd1);
    check("ack:ready1",  64'(rdy64), 64'd1);
    check("ack:count0",  64'(cnt64), 64'd0);

    // Duplicate ID 7: last value wins, publish only after 64 distinct IDs.
    cyc("dup", 1'b1, 6'd7, 16'h0010, 1'b0, 1'b0);
    cyc("dup", 1'b1, 6'd7, 16'h0020, 1'b0, 1'b0);
    check("dup:pulse", 64'(dup64), 64'd1);
    for (int i = 0; i < N; i++)
      if (i != 7) cyc("dup", 1'b1, 6'(i), 16'($urandom), 1'b0, 1'b0);
    e = so64[7*E +: E];
    check("dup:entry7", 64'(e), 64'({16'h0020, 6'd7}));
    cyc("dup_ack", 1'b0, 6'd0, 16'd0, 1'b0, 1'b1);

    // Flush mid-round with a same-edge beat, then a normal round.
    for (int i = 0; i < 40; i++) cyc("flush", 1'b1, 6'(i), 16'(500 + i), 1'b0, 1'b0);
    cyc("flush", 1'b1, 6'd41, 16'h4141, 1'b1, 1'b0);
    check("flush:count0", 64'(cnt64), 64'd0);
    check("flush:no_dup", 64'(dup64), 64'd0);
    full_round("after_flush", 1000);
    check("after_flush:valid", 64'(ov64), 64'd1);
    // flush wins over a same-edge ack: no round counted.
    cyc("flush_ack", 1'b0, 6'd0, 16'd0, 1'b1, 1'b1);
    check("flush_ack:rounds", 64'(rnd64), 64'd2);
    // ack with nothing on offer is ignored.
    cyc("stray_ack", 1'b0, 6'd0, 16'd0, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) rand_round($sformatf("rand%0d", r));

    // Asynchronous reset in the middle of PUBLISH, away from the clock edge.
    full_round("prereset", 7);
    cyc("prereset", 1'b1, 6'd9, 16'h9999, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("areset:out_valid", 64'(ov64),  64'd0);
    check("areset:count",     64'(cnt64), 64'd0);
    check("areset:rounds",    64'(rnd64), 64'd0);
    check("areset:vector0",   64'(so64 == '0), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("post_reset", 1'b0, 6'd0, 16'd0, 1'b0, 1'b0);
    check("post_reset:ready", 64'(rdy64), 64'd1);
    full_round("post_reset", 3000);
    cyc("post_reset_ack", 1'b0, 6'd0, 16'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/score_collector.md
Name: score_collector

Overview:
- Front end of the ranking stage. Gathers per-node PageRank scores arriving one at a time from the NoC as (node ID, score) beats.
- Assembles them into the packed N-entry score vector consumed by the top-10 sorter.
- Publishes the vector with a valid/ack handshake once every node has reported in the current round.

Parameters:
- N, 64, number of nodes / vector entries; 1..64 (ID field fixed at 6 bits).
- WIDTH, 16, score width in bits.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  score beat valid.
- in_ready  output  1  collector can accept a beat.
- in_id  input  6  node ID of beat.
- in_score  input  WIDTH  score of beat.
- flush  input  1  synchronous abort of current round.
- out_valid  output  1  packed vector complete and stable.
- out_ack  input  1  sorter has taken the vector.
- scores_out  output  N*(WIDTH+6)  packed vector. Entry m occupies bits [m*(WIDTH+6)+WIDTH+5 : m*(WIDTH+6)]. Within an entry, [5:0] = ID (equals m) and [WIDTH+5:6] = score.
- count  output  7  distinct IDs received this round.
- dup_err  output  1  one-cycle pulse: accepted beat repeated an ID already seen this round.
- oob_err  output  1  one-cycle pulse: accepted beat had in_id >= N.
- rounds  output  8  completed (acked) rounds, wraps 255->0.

Behaviour:
- Reset: asynchronous, active-high; clock clk.
- Reset values: state COLLECT, in_ready=1, out_valid=0, scores_out=0, count=0, seen mask=0, dup_err=0, oob_err=0, rounds=0.
- States: COLLECT, PUBLISH.
- in_ready = (state==COLLECT); it is a registered state decode, never combinational from inputs.
- Beat accepted on a rising edge with in_valid && in_ready.
- COLLECT, accepted beat with in_id < N and seen[in_id]=0:
  - write score field of entry in_id; ID field written with in_id;
  - set seen[in_id]; count+1.
- COLLECT, accepted beat with in_id < N and seen[in_id]=1:
  - overwrite score (last value wins); count unchanged;
  - dup_err=1 next cycle for one cycle.
- COLLECT, accepted beat with in_id >= N:
  - discard beat; no state change;
  - oob_err=1 next cycle for one cycle.
- COLLECT -> PUBLISH on the edge where the accepted beat brings count to N.
  - out_valid=1 and in_ready=0 from the following cycle, i.e. one cycle after the final accept edge.
- PUBLISH:
  - scores_out and count held stable; in_valid ignored.
  - On an edge with out_ack=1: clear seen and count, rounds+1, out_valid=0, return to COLLECT. in_ready=1 the cycle after the ack edge.
  - out_ack while out_valid=0 is ignored.
- flush (either state), sampled on edge:
  - clear seen and count; out_valid=0; state COLLECT; rounds unchanged;
  - scores_out entries retain old contents.
  - A beat accepted on the same edge as flush is discarded; no error pulses.
- Precedence: flush beats out_ack on the same edge, so rounds does not increment.
- Stale data: scores_out slot contents persist across rounds. Publication requires all N IDs seen, so every slot is rewritten before out_valid rises.
- Score width: no arithmetic; scores are stored verbatim at WIDTH bits.
- Reset mid-round or mid-publish: everything returns immediately to reset values.
- Two-deep throughput: none. There is one vector buffer, and no beats are accepted during PUBLISH.

Test Plan:
- Reset, then send IDs 0..63 in order, score = 100+ID, one per cycle -> out_valid=1 the cycle after the ID 63 beat. Entry 63 = {16'd163, 6'd63}. count=64, in_ready=0.
- During PUBLISH, hold in_valid=1 with ID 5, score 0xFFFF for 10 cycles; then pulse out_ack -> scores_out unchanged throughout. rounds=1. in_ready=1 the cycle after the ack; count=0.
- Round with ID 7 sent twice (0x0010, then 0x0020) plus all others -> dup_err one-cycle pulse after the second send. Final entry 7 score 0x0020. Publish occurs only after the 64th distinct ID.
- Send in_id=6'd63 with N=32 parameterisation -> oob_err pulse, count unchanged, no entry modified.
- Send 40 IDs, then assert flush together with a valid beat for ID 41 -> count=0, out_valid=0, no error pulse. A subsequent full 64-ID round publishes normally.
- Assert async reset mid-way through PUBLISH (not clock-aligned) -> out_valid, count, rounds and scores_out read 0 immediately. in_ready=1 after reset deasserts.
